battle_round_controller: RTL and testbench
==========================================

// Module: battle_round_controller
// PURPOSE
//   Sequences the per-frame damage calculation pass over the 8 bullet slots. Each
//   frame it pulses the calculator start, waits for its complete flag, then applies
//   the returned damage/heal to player HP. Owns HP, invulnerability frames and game
//   over. Sits between the frame timing logic and the bullet/collision datapath.
// PARAMETERS
//   MAX_HP    100  HP at reset and heal saturation ceiling (1..255)
//   HEAL_AMT  10   HP added when calcHeal=1 in a pass
//   IFRAMES   2    frameTicks of invulnerability after damage is applied (0 = none)
//   TIMEOUT   16   clk cycles allowed in WAIT for calcDone before abort (>=10)
// PORTS
//   clk           in   1  system clock, all logic on posedge
//   reset         in   1  synchronous, active-high
//   frameTick     in   1  one-cycle pulse, start of a frame
//   enable        in   1  1 = battle phase active; 0 = frameTicks do not start passes
//   calcStart     out  1  one-cycle start pulse to the damage calculator
//   calcDone      in   1  calculator complete flag (one-cycle pulse)
//   calcDamage    in   8  calculator accumulated damage, valid with calcDone
//   calcHeal      in   1  calculator heal flag, valid with calcDone
//   hp            out  8  current player HP
//   hitFlash      out  1  1 while invulnerability counter != 0
//   gameOver      out  1  1 once HP reaches 0; held until reset
//   busy          out  1  1 in START/WAIT/APPLY
//   timeoutErr    out  1  sticky: a pass aborted on timeout
//   frameOverrun  out  1  sticky: frameTick arrived while busy
// BEHAVIOUR
//   Reset: hp=MAX_HP, state=IDLE, invuln=0; calcStart, hitFlash, gameOver, busy,
//     timeoutErr, frameOverrun all 0. Reset mid-pass abandons the pass; no HP update.
//   States: IDLE, START, WAIT, APPLY, DEAD.
//   IDLE: frameTick & enable -> START. Otherwise hold.
//   START: calcStart=1 for exactly this cycle; wait timer cleared; -> WAIT.
//   WAIT: calcDone=1 -> latch calcDamage/calcHeal, -> APPLY. Timer counts each cycle;
//     timer==TIMEOUT-1 without calcDone -> timeoutErr=1, -> IDLE, hp unchanged.
//   APPLY (one cycle): d = (invuln!=0) ? 0 : latched damage.
//     hp_d = (d >= hp) ? 0 : hp - d (saturating, 8-bit, never wraps).
//     hp_d==0 -> hp=0, gameOver=1, -> DEAD; heal ignored.
//     else hp = min(hp_d + HEAL_AMT, MAX_HP) if heal, else hp_d (9-bit compare).
//     If d!=0: invuln reloads IFRAMES. -> IDLE.
//   DEAD: all inputs ignored, calcStart=0, busy=0; exit only via reset.
//   invuln: decrements by 1 on each frameTick while >0 (all states except DEAD);
//     APPLY reload takes priority over a same-cycle decrement.
//   frameTick while busy: dropped (no queued pass), frameOverrun=1.
//   busy is registered from state; calcStart is not asserted in any other state.
//   Latency: frameTick sampled at edge t -> calcStart high in cycle t+1. calcDone
//     sampled at edge u -> APPLY in cycle u+1 -> new hp visible from cycle u+2.
//   calcDone outside WAIT is ignored. enable low does not abort an in-flight pass.
// TESTING (MAX_HP=100, HEAL_AMT=10, IFRAMES=2, TIMEOUT=16)
//   Reset -> hp=100, all flags 0, calcStart never pulses while enable=0 with frameTicks.
//   frameTick; calcDone after 9 cycles with damage=50 -> one calcStart pulse, hp=50, hitFlash=1.
//   Next pass damage=50 with invuln=1 -> hp stays 50; after 2 frameTicks hitFlash=0;
//     then damage=50 -> hp=0, gameOver=1, further frameTicks give no calcStart.
//   hp=95, damage=0 heal=1 -> hp=100; hp=60, damage=50 heal=1 -> hp=20; hp=40,
//     damage=200 heal=1 -> hp=0, gameOver=1.
//   calcDone withheld 16 cycles -> timeoutErr=1, back to IDLE, hp unchanged; late
//     calcDone ignored.
//   frameTick during WAIT -> frameOverrun=1, exactly one calcStart; reset in WAIT ->
//     hp=100, flags cleared.

Source files
------------

// File: rtl/battle_round_controller.sv
// battle_round_controller
//   Sequences one damage-calculation pass per enabled frame. It pulses the
//   calculator start, waits a bounded number of cycles for the calculator to
//   finish, then applies the returned damage/heal to player HP. It also owns
//   the invulnerability frames, game over and the sticky error flags.
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_frame_tick, i_enable  frame pulse and battle-phase enable
//   o_calc_start            one-cycle start pulse to the damage calculator
//   i_calc_done             calculator complete pulse
//   i_calc_damage/heal      calculator results, valid with i_calc_done
//   o_hp                    current player HP
//   o_hit_flash             high while invulnerability is active
//   o_game_over             high once HP reaches 0, held until reset
//   o_busy                  high in START/WAIT/APPLY
//   o_timeout_err           sticky: a pass was aborted on timeout
//   o_frame_overrun         sticky: a frame tick arrived while busy
module battle_round_controller #(
    parameter int unsigned MAX_HP   = 100,
    parameter int unsigned HEAL_AMT = 10,
    parameter int unsigned IFRAMES  = 2,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_tick,
    input  logic       i_enable,
    output logic       o_calc_start,
    input  logic       i_calc_done,
    input  logic [7:0] i_calc_damage,
    input  logic       i_calc_heal,
    output logic [7:0] o_hp,
    output logic       o_hit_flash,
    output logic       o_game_over,
    output logic       o_busy,
    output logic       o_timeout_err,
    output logic       o_frame_overrun
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned IW = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_APPLY = 3'd3;
    localparam logic [2:0] S_DEAD  = 3'd4;

    logic [2:0]    r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [IW-1:0] r_invuln, w_invuln_nxt;
    logic [7:0]    r_hp, w_hp_nxt;
    logic [7:0]    r_dmg, w_dmg_nxt;
    logic          r_heal, w_heal_nxt;
    logic          r_calc_start, r_busy, r_hit_flash;
    logic          r_game_over, w_game_over_nxt;
    logic          r_timeout_err, w_timeout_err_nxt;
    logic          r_frame_overrun, w_frame_overrun_nxt;

    // Damage application arithmetic; only consumed in APPLY
    logic [7:0] w_d;
    logic [7:0] w_hp_sub;
    logic [8:0] w_hp_heal;
    logic [7:0] w_hp_cap;

    always_comb begin
        w_d       = (r_invuln != '0) ? 8'd0 : r_dmg;
        w_hp_sub  = (w_d >= r_hp) ? 8'd0 : r_hp - w_d;
        w_hp_heal = {1'b0, w_hp_sub} + 9'(HEAL_AMT);
        w_hp_cap  = (w_hp_heal > 9'(MAX_HP)) ? 8'(MAX_HP) : w_hp_heal[7:0];
    end

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt         = r_state;
        w_timer_nxt         = r_timer;
        w_invuln_nxt        = r_invuln;
        w_hp_nxt            = r_hp;
        w_dmg_nxt           = r_dmg;
        w_heal_nxt          = r_heal;
        w_game_over_nxt     = r_game_over;
        w_timeout_err_nxt   = r_timeout_err;
        w_frame_overrun_nxt = r_frame_overrun;

        // Invulnerability runs on frame time; frozen once dead
        if (r_state != S_DEAD && i_frame_tick && r_invuln != '0) begin
            w_invuln_nxt = r_invuln - IW'(1);
        end

        // A tick while a pass is in flight is dropped, not queued
        if (i_frame_tick && r_busy) begin
            w_frame_overrun_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (i_frame_tick && i_enable) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_calc_done) begin
                    w_dmg_nxt   = i_calc_damage;
                    w_heal_nxt  = i_calc_heal;
                    w_state_nxt = S_APPLY;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_APPLY: begin
                if (w_hp_sub == 8'd0) begin
                    w_hp_nxt        = 8'd0;
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = S_DEAD;
                end else begin
                    w_hp_nxt    = r_heal ? w_hp_cap : w_hp_sub;
                    w_state_nxt = S_IDLE;
                end
                // Reload wins over a same-cycle frame-tick decrement
                if (w_d != 8'd0) begin
                    w_invuln_nxt = IW'(IFRAMES);
                end
            end
            S_DEAD: begin
                w_state_nxt = S_DEAD;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; outputs follow the next state so they align with it
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_timer         <= '0;
            r_invuln        <= '0;
            r_hp            <= 8'(MAX_HP);
            r_dmg           <= 8'd0;
            r_heal          <= 1'b0;
            r_calc_start    <= 1'b0;
            r_busy          <= 1'b0;
            r_hit_flash     <= 1'b0;
            r_game_over     <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_frame_overrun <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_timer         <= w_timer_nxt;
            r_invuln        <= w_invuln_nxt;
            r_hp            <= w_hp_nxt;
            r_dmg           <= w_dmg_nxt;
            r_heal          <= w_heal_nxt;
            r_calc_start    <= (w_state_nxt == S_START);
            r_busy          <= (w_state_nxt == S_START) || (w_state_nxt == S_WAIT) ||
                               (w_state_nxt == S_APPLY);
            r_hit_flash     <= (w_invuln_nxt != '0);
            r_game_over     <= w_game_over_nxt;
            r_timeout_err   <= w_timeout_err_nxt;
            r_frame_overrun <= w_frame_overrun_nxt;
        end
    end

    assign o_calc_start    = r_calc_start;
    assign o_hp            = r_hp;
    assign o_hit_flash     = r_hit_flash;
    assign o_game_over     = r_game_over;
    assign o_busy          = r_busy;
    assign o_timeout_err   = r_timeout_err;
    assign o_frame_overrun = r_frame_overrun;

endmodule

// File: tb/tb_battle_round_controller.sv
// tb_battle_round_controller
//   Directed bench for battle_round_controller with default parameters
//   (MAX_HP=100, HEAL_AMT=10, IFRAMES=2, TIMEOUT=16).
module tb_battle_round_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic       calc_start;
    logic       calc_done = 1'b0;
    logic [7:0] calc_damage = 8'd0;
    logic       calc_heal = 1'b0;
    logic [7:0] hp;
    logic       hit_flash;
    logic       game_over;
    logic       busy;
    logic       timeout_err;
    logic       frame_overrun;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;

    always #5 clk = ~clk;

    battle_round_controller dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_frame_tick    (frame_tick),
        .i_enable        (enable),
        .o_calc_start    (calc_start),
        .i_calc_done     (calc_done),
        .i_calc_damage   (calc_damage),
        .i_calc_heal     (calc_heal),
        .o_hp            (hp),
        .o_hit_flash     (hit_flash),
        .o_game_over     (game_over),
        .o_busy          (busy),
        .o_timeout_err   (timeout_err),
        .o_frame_overrun (frame_overrun)
    );

    // Count start pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (calc_start === 1'b1) n_starts++;
    end

    typedef struct {
        bit         rst;
        int         drain;
        logic [7:0] dmg;
        bit         heal;
        int         delay;
        logic [7:0] exp_hp;
        bit         exp_flash;
        bit         chk_flash;
        bit         exp_go;
    } pass_t;

    pass_t rows[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        frame_tick = 1'b0;
        calc_done = 1'b0;
        enable = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic tick(input bit en);
        enable = en;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        enable = 1'b0;
    endtask

    // One full pass: tick, calcDone after 'delay' cycles, ends with new hp visible
    task automatic run_pass(input logic [7:0] dmg, input bit heal, input int delay);
        int s0;
        s0 = n_starts;
        tick(1'b1);
        check("calc_start_pulse", 32'(calc_start), 32'd1);
        step(delay);
        calc_done = 1'b1;
        calc_damage = dmg;
        calc_heal = heal;
        step(1);
        calc_done = 1'b0;
        calc_damage = 8'd0;
        calc_heal = 1'b0;
        step(1);
        check("starts_per_pass", 32'(n_starts - s0), 32'd1);
    endtask

    initial begin
        int s0;

        //        rst drain dmg   heal dly  hp   flash chkf go
        rows[0] = '{1'b1, 0, 8'd50,  1'b0, 9,  8'd50,  1'b1, 1'b1, 1'b0};
        rows[1] = '{1'b0, 0, 8'd50,  1'b0, 1,  8'd50,  1'b1, 1'b1, 1'b0};
        rows[2] = '{1'b0, 2, 8'd50,  1'b0, 16, 8'd0,   1'b0, 1'b0, 1'b1};
        rows[3] = '{1'b1, 0, 8'd5,   1'b0, 3,  8'd95,  1'b1, 1'b1, 1'b0};
        rows[4] = '{1'b0, 2, 8'd0,   1'b1, 5,  8'd100, 1'b0, 1'b1, 1'b0};
        rows[5] = '{1'b0, 0, 8'd40,  1'b0, 2,  8'd60,  1'b1, 1'b1, 1'b0};
        rows[6] = '{1'b0, 2, 8'd50,  1'b1, 7,  8'd20,  1'b1, 1'b1, 1'b0};
        rows[7] = '{1'b1, 0, 8'd60,  1'b0, 4,  8'd40,  1'b1, 1'b1, 1'b0};
        rows[8] = '{1'b0, 2, 8'd200, 1'b1, 10, 8'd0,   1'b0, 1'b0, 1'b1};

        // Reset state and disabled frame ticks
        step(3);
        reset = 1'b0;
        check("rst_hp", 32'(hp), 32'd100);
        check("rst_flags", 32'({calc_start, hit_flash, game_over, busy, timeout_err, frame_overrun}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            step(1);
        end
        step(2);
        check("disabled_no_start", 32'(n_starts), 32'd0);
        check("disabled_not_busy", 32'(busy), 32'd0);

        // Table-driven passes
        for (int i = 0; i < 9; i++) begin
            if (rows[i].rst) do_reset();
            if (rows[i].drain > 0) begin
                for (int k = 0; k < rows[i].drain; k++) tick(1'b0);
                check("drain_flash", 32'(hit_flash), 32'd0);
            end
            run_pass(rows[i].dmg, rows[i].heal, rows[i].delay);
            check($sformatf("row%0d_hp", i), 32'(hp), 32'(rows[i].exp_hp));
            if (rows[i].chk_flash)
                check($sformatf("row%0d_flash", i), 32'(hit_flash), 32'(rows[i].exp_flash));
            check($sformatf("row%0d_game_over", i), 32'(game_over), 32'(rows[i].exp_go));
            check($sformatf("row%0d_busy", i), 32'(busy), 32'd0);
        end

        // DEAD ignores ticks and calcDone
        s0 = n_starts;
        tick(1'b1);
        step(1);
        tick(1'b1);
        calc_done = 1'b1;
        calc_damage = 8'd0;
        calc_heal = 1'b1;
        step(1);
        calc_done = 1'b0;
        calc_heal = 1'b0;
        step(3);
        check("dead_no_start", 32'(n_starts - s0), 32'd0);
        check("dead_busy", 32'(busy), 32'd0);
        check("dead_hp", 32'(hp), 32'd0);
        check("dead_game_over", 32'(game_over), 32'd1);

        // Timeout: 16 WAIT cycles without calcDone
        do_reset();
        s0 = n_starts;
        tick(1'b1);
        step(16);
        check("wait_last_busy", 32'(busy), 32'd1);
        check("wait_last_no_timeout", 32'(timeout_err), 32'd0);
        step(1);
        check("timeout_err", 32'(timeout_err), 32'd1);
        check("timeout_idle", 32'(busy), 32'd0);
        check("timeout_hp", 32'(hp), 32'd100);
        calc_done = 1'b1;
        calc_damage = 8'd50;
        step(1);
        calc_done = 1'b0;
        calc_damage = 8'd0;
        step(2);
        check("late_done_hp", 32'(hp), 32'd100);
        check("late_done_busy", 32'(busy), 32'd0);
        check("timeout_starts", 32'(n_starts - s0), 32'd1);
        check("timeout_sticky", 32'(timeout_err), 32'd1);

        // Frame tick during WAIT: overrun, dropped tick
        do_reset();
        s0 = n_starts;
        tick(1'b1);
        step(3);
        check("pre_overrun", 32'(frame_overrun), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        tick(1'b1);
        check("overrun_set", 32'(frame_overrun), 32'd1);
        step(2);
        calc_done = 1'b1;
        calc_damage = 8'd10;
        step(1);
        calc_done = 1'b0;
        calc_damage = 8'd0;
        step(3);
        check("overrun_hp", 32'(hp), 32'd90);
        check("overrun_one_start", 32'(n_starts - s0), 32'd1);

        // Reset in WAIT abandons the pass
        tick(1'b1);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        calc_done = 1'b1;
        calc_damage = 8'd30;
        step(1);
        calc_done = 1'b0;
        calc_damage = 8'd0;
        step(2);
        check("rst_wait_hp", 32'(hp), 32'd100);
        check("rst_wait_flags", 32'({hit_flash, game_over, busy, timeout_err, frame_overrun}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
